lif_layer: RTL and testbench
============================

# lif_layer

Time-multiplexed leaky-integrate-and-fire layer: one arithmetic datapath serves N_NEURONS neurons. Membrane potentials and refractory counters live in internal storage. Per timestep the block consumes one signed input current per neuron in index order over a valid/ready stream. For each neuron it emits a spike flag tagged with the neuron index, then pulses `done`. It sits between the synapse accumulator, which produces the current stream, and the spike router, which consumes `spk_*`. It replaces per-neuron LIF instances wired to external BRAM.

## Interface
- `WIDTH`, 16: signed membrane/current width.
- `N_NEURONS`, 64: neurons per layer, ≥2.
- `THRESH`, 32: firing threshold, signed, 0 < THRESH < 2^(WIDTH-1)-1.
- `RESET_VAL`, 0: membrane value after a spike or clear.
- `LEAK_SHIFT`, 1: arithmetic right-shift applied when leaking; 0 disables leak.
- `REFRAC`, 2: refractory timesteps after a spike; 0 disables.
- `ADDR_W`, $clog2(N_NEURONS): index width (derived).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: request to write RESET_VAL and refractory 0 to every neuron.
- `start` in 1: request one timestep.
- `leak_en` in 1: sampled at start; apply leak this timestep.
- `cur_valid` in 1 / `cur_ready` out 1 / `cur_data` in WIDTH signed: input current stream.
- `spk_valid` out 1: result strobe.
- `spk_idx` out ADDR_W: neuron index of the result.
- `spk_out` out 1: neuron fired.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle end-of-timestep pulse.

## Operation
- States: IDLE, CLEAR, STEP.
- IDLE: `clear` → CLEAR, idx=0. Else `start` → STEP, idx=0, latch `leak_en`. If both are high, `clear` wins and `start` is dropped.
- CLEAR: one neuron per cycle: mem[idx]=RESET_VAL, ref[idx]=0. After idx=N_NEURONS-1 → IDLE. No `done`.
- STEP: `cur_ready`=1. Each beat with valid&ready updates neuron idx, then idx+1. The beat at idx=N_NEURONS-1 → IDLE.
- `start` and `clear` are ignored while busy.
- Per-neuron update for current c and membrane m:
  - If ref[idx]≠0: ref−1, mem=RESET_VAL, no spike, c discarded.
  - Else s = m + c, computed WIDTH+1 wide, saturated to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - If s ≥ THRESH: spike, mem=RESET_VAL, ref=REFRAC.
  - Else: v = leak ? (s >>> LEAK_SHIFT) : s. Then mem = max(v, −THRESH), a floor clamp.
- Membrane and refractory storage is not touched by `rst_n`. Software must issue `clear` after reset.

## Timing
- Reset values: `cur_ready`=0, `spk_valid`=0, `spk_idx`=0, `spk_out`=0, `busy`=0, `done`=0; state IDLE, idx 0.
- Request to busy: `start` or `clear` seen in cycle t → `busy`=1 from t+1. `cur_ready`=1 from t+1 for a start.
- Result latency: beat accepted in cycle t → `spk_valid`=1 in t+1 for exactly one cycle, with `spk_idx`/`spk_out` for that neuron. At full rate there is one result per cycle.
- Downstream has no backpressure; the consumer must always accept `spk_*`.
- Bubbles: `cur_valid` low stalls the step. idx holds and no `spk_valid` is produced.
- End of step: the final beat is accepted in t. `cur_ready` and `busy` are 0 from t+1. In t+1, `spk_valid` (idx N_NEURONS-1) and `done` are both high.
- Back-to-back: `start` may be asserted in the `done` cycle. The new step's `cur_ready` rises the following cycle.
- CLEAR takes N_NEURONS cycles. `busy` falls the cycle after idx=N_NEURONS-1 is written.
- `rst_n` asserted mid-step or mid-clear:
  - State → IDLE immediately.
  - Pending `spk_valid`/`done` are suppressed.
  - Partially updated membranes are retained as-is.
- Throughput: N_NEURONS+1 cycles per step, start to `done`, with no bubbles.

## Test plan
- Reset, clear, then step with all currents 0 → 64 `spk_valid`, all `spk_out`=0, idx 0..63 in order. `done` coincides with idx 63.
- Neuron 5: c=20 for two steps, no leak → step 1 no spike (mem 20), step 2 spike (40≥32). Step 3 with c=40: no spike (refractory 2). Step 4 same. Step 5 with c=40: spike.
- Leak: mem 0, c=30, leak_en=1 → mem 15. Next step c=16 → 31, no spike; leaked → 15.
- Saturation, WIDTH=16: mem −32 with c=−32768 → clamped, mem=−32. c=32767 into mem 31 → saturates to 32767, spike, mem=RESET_VAL.
- Stalls: random `cur_valid` gaps, plus `start` asserted while busy → idx order preserved, `start` ignored, exactly one `done` per step.
- `rst_n` pulse at idx 30 → no `done`. A subsequent step restarts at idx 0 and sees membranes 0..29 updated.

Source files
------------

// File: rtl/lif_layer.sv
// Time-multiplexed LIF layer: one datapath walks N_NEURONS neurons per timestep; result 1 cycle after each accepted beat.
// Backpressure only on the input (cur_ready high in STEP); spk_*/done have no backpressure and must always be taken.
module lif_layer #(
  parameter int WIDTH      = 16,
  parameter int N_NEURONS  = 64,
  parameter int THRESH     = 32,
  parameter int RESET_VAL  = 0,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int ADDR_W     = $clog2(N_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    leak_en,
  input  logic                    cur_valid,
  output logic                    cur_ready,
  input  logic signed [WIDTH-1:0] cur_data,
  output logic                    spk_valid,
  output logic [ADDR_W-1:0]       spk_idx,
  output logic                    spk_out,
  output logic                    busy,
  output logic                    done
);

  localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [ADDR_W-1:0]       LAST_IDX  = ADDR_W'(N_NEURONS - 1);
  localparam logic [REF_W-1:0]        REF_INIT  = REF_W'(REFRAC);
  localparam logic signed [WIDTH-1:0] THR_V     = WIDTH'(THRESH);
  localparam logic signed [WIDTH-1:0] NEG_THR_V = -THR_V;
  localparam logic signed [WIDTH-1:0] RST_V     = WIDTH'(RESET_VAL);
  localparam logic signed [WIDTH-1:0] MAX_V     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V     = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_STEP
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                leak_q;
  logic                spk_valid_q;
  logic [ADDR_W-1:0]   spk_idx_q;
  logic                spk_out_q;
  logic                done_q;

  // Neuron state is deliberately outside rst_n; software clears it explicitly.
  logic signed [WIDTH-1:0] mem_q     [N_NEURONS];
  logic [REF_W-1:0]        ref_cnt_q [N_NEURONS];

  logic                    beat;
  logic                    clearing;
  logic signed [WIDTH-1:0] mem_cur;
  logic [REF_W-1:0]        ref_cur;
  logic [WIDTH:0]          sum_w;
  logic signed [WIDTH-1:0] sat;
  logic signed [WIDTH-1:0] leaked;
  logic signed [WIDTH-1:0] floored;
  logic                    fire;
  logic signed [WIDTH-1:0] mem_d;
  logic [REF_W-1:0]        ref_d;

  assign beat     = (state_q == S_STEP) && cur_valid;
  assign clearing = (state_q == S_CLEAR);
  assign mem_cur  = mem_q[idx_q];
  assign ref_cur  = ref_cnt_q[idx_q];

  // Sign-extended add; the two top bits disagree exactly on overflow.
  assign sum_w = {mem_cur[WIDTH-1], mem_cur} + {cur_data[WIDTH-1], cur_data};

  always_comb begin
    sat = sum_w[WIDTH-1:0];
    if (sum_w[WIDTH] != sum_w[WIDTH-1]) begin
      sat = sum_w[WIDTH] ? MIN_V : MAX_V;
    end
  end

  assign fire    = (ref_cur == '0) && (sat >= THR_V);
  assign leaked  = leak_q ? (sat >>> LEAK_SHIFT) : sat;
  assign floored = (leaked < NEG_THR_V) ? NEG_THR_V : leaked;

  always_comb begin
    mem_d = floored;
    ref_d = '0;
    if (clearing) begin
      mem_d = RST_V;
      ref_d = '0;
    end else if (ref_cur != '0) begin
      mem_d = RST_V;
      ref_d = ref_cur - REF_W'(1);
    end else if (fire) begin
      mem_d = RST_V;
      ref_d = REF_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (beat || clearing) begin
      mem_q[idx_q]     <= mem_d;
      ref_cnt_q[idx_q] <= ref_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      leak_q      <= 1'b0;
      spk_valid_q <= 1'b0;
      spk_idx_q   <= '0;
      spk_out_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      spk_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
          end else if (start) begin
            state_q <= S_STEP;
            idx_q   <= '0;
            leak_q  <= leak_en;
          end
        end
        S_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        S_STEP: begin
          if (cur_valid) begin
            spk_valid_q <= 1'b1;
            spk_idx_q   <= idx_q;
            spk_out_q   <= fire;
            if (idx_q == LAST_IDX) begin
              state_q <= S_IDLE;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cur_ready = (state_q == S_STEP);
  assign busy      = (state_q != S_IDLE);
  assign spk_valid = spk_valid_q;
  assign spk_idx   = spk_idx_q;
  assign spk_out   = spk_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer with default parameters (64 neurons, THRESH 32, REFRAC 2, leak shift 1).
module tb_lif_layer;
  localparam int N = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               start;
  logic               leak_en;
  logic               cur_valid;
  logic               cur_ready;
  logic signed [15:0] cur_data;
  logic               spk_valid;
  logic [5:0]         spk_idx;
  logic               spk_out;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  lif_layer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .leak_en(leak_en),
    .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_data(cur_data),
    .spk_valid(spk_valid), .spk_idx(spk_idx), .spk_out(spk_out),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  logic signed [15:0] cur_vec [N];
  logic               res_spk [N];
  int   n_res, n_spk, order_err, done_cnt, done_bad, step_cycles, timed_out;
  logic busy_after, rdy_after;

  // Drives one timestep from a negedge and records results; returns on the negedge where done is seen.
  task automatic run_step(input logic lk, input int gap_pct, input bit poke_start,
                          input bit chain, input bit skip_start);
    int   k = 0;
    int   exp_idx = 0;
    int   cyc = 0;
    bit   got_done = 0;
    logic last_v = 1'b0;
    logic last_r = 1'b0;
    n_res = 0; n_spk = 0; order_err = 0; done_cnt = 0; done_bad = 0;
    step_cycles = 0; timed_out = 0;
    for (int i = 0; i < N; i++) res_spk[i] = 1'bx;
    if (!skip_start) begin
      start = 1'b1; leak_en = lk;
      @(negedge clk);
    end
    while (!got_done && cyc < 1000) begin
      start = 1'b0;
      if (spk_valid) begin
        if (int'(spk_idx) != exp_idx) order_err++;
        res_spk[spk_idx] = spk_out;
        n_res++;
        if (spk_out) n_spk++;
        exp_idx++;
      end
      if (last_v && last_r) k++;
      if (done) begin
        got_done = 1;
        done_cnt++;
        if (!(spk_valid && spk_idx == 6'd63)) done_bad++;
        step_cycles = cyc + 1;
        busy_after = busy;
        rdy_after = cur_ready;
        cur_valid = 1'b0;
        start = chain;
        leak_en = 1'b0;
      end else begin
        cur_valid = (k < N) && (gap_pct == 0 || int'($urandom_range(99, 0)) >= gap_pct);
        if (k < N) cur_data = cur_vec[k];
        else cur_data = '0;
        if (poke_start && k < N) start = ($urandom_range(1, 0) == 1);
        last_v = cur_valid;
        last_r = cur_ready;
        cyc++;
        @(negedge clk);
      end
    end
    if (!got_done) timed_out = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; leak_en = 1'b0;
    cur_valid = 1'b0; cur_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (spk_valid !== 1'b0) begin failures++; $display("FAIL reset_spk_valid: got %b expected 0", spk_valid); end
    checks++; if (spk_idx !== 6'd0) begin failures++; $display("FAIL reset_spk_idx: got %0d expected 0", spk_idx); end
    checks++; if (spk_out !== 1'b0) begin failures++; $display("FAIL reset_spk_out: got %b expected 0", spk_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cur_ready !== 1'b0) begin failures++; $display("FAIL reset_cur_ready: got %b expected 0", cur_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // clear and start together: clear wins, takes N cycles, no done.
  task automatic test_clear();
    int cnt = 0;
    bit saw_done = 0;
    bit saw_rdy = 0;
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy: got %b expected 1", busy); end
    while (busy && cnt < 200) begin
      if (done) saw_done = 1;
      if (cur_ready) saw_rdy = 1;
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 64) begin failures++; $display("FAIL clear_cycles: got %0d expected 64", cnt); end
    checks++; if (saw_done) begin failures++; $display("FAIL clear_done: got 1 expected 0"); end
    checks++; if (saw_rdy) begin failures++; $display("FAIL clear_start_dropped: cur_ready got 1 expected 0"); end
  endtask

  task automatic test_zero_step();
    for (int i = 0; i < N; i++) cur_vec[i] = '0;
    run_step(1'b0, 0, 0, 0, 0);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL zero_timeout: got %0d expected 0", timed_out); end
    checks++; if (n_res != 64) begin failures++; $display("FAIL zero_results: got %0d expected 64", n_res); end
    checks++; if (order_err != 0) begin failures++; $display("FAIL zero_order: got %0d expected 0", order_err); end
    checks++; if (n_spk != 0) begin failures++; $display("FAIL zero_spikes: got %0d expected 0", n_spk); end
    checks++; if (done_bad != 0) begin failures++; $display("FAIL zero_done_at_63: got %0d expected 0", done_bad); end
    checks++; if (step_cycles != 65) begin failures++; $display("FAIL zero_cycles: got %0d expected 65", step_cycles); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL zero_busy_end: got %b expected 0", busy_after); end
    checks++; if (rdy_after !== 1'b0) begin failures++; $display("FAIL zero_ready_end: got %b expected 0", rdy_after); end
  endtask

  task automatic test_refractory();
    logic signed [15:0] cv [5];
    logic               ex [5];
    cv = '{16'sd20, 16'sd20, 16'sd40, 16'sd40, 16'sd40};
    ex = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < N; i++) cur_vec[i] = '0;
      cur_vec[5] = cv[s];
      run_step(1'b0, 0, 0, 0, 0);
      checks++; if (timed_out != 0 || n_res != 64) begin failures++; $display("FAIL refrac_step%0d_results: got %0d expected 64", s, n_res); end
      checks++; if (res_spk[5] !== ex[s]) begin failures++; $display("FAIL refrac_step%0d_n5: got %b expected %b", s, res_spk[5], ex[s]); end
      checks++; if (n_spk != int'(ex[s])) begin failures++; $display("FAIL refrac_step%0d_total: got %0d expected %0d", s, n_spk, ex[s]); end
    end
  endtask

  task automatic test_leak();
    logic signed [15:0] cv [4];
    logic               lk [4];
    logic               ex [4];
    cv = '{16'sd30, 16'sd16, 16'sd16, 16'sd1};
    lk = '{1'b1, 1'b1, 1'b0, 1'b0};
    ex = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < N; i++) cur_vec[i] = '0;
      cur_vec[7] = cv[s];
      run_step(lk[s], 0, 0, 0, 0);
      checks++; if (timed_out != 0 || n_res != 64) begin failures++; $display("FAIL leak_step%0d_results: got %0d expected 64", s, n_res); end
      checks++; if (res_spk[7] !== ex[s]) begin failures++; $display("FAIL leak_step%0d_n7: got %b expected %b", s, res_spk[7], ex[s]); end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] cv [8];
    logic               ex [8];
    cv = '{-16'sd100, -16'sd32768, 16'sd63, 16'sd32767, 16'sd0, 16'sd0, 16'sd31, 16'sd1};
    ex = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) cur_vec[i] = '0;
      cur_vec[10] = cv[s];
      run_step(1'b0, 0, 0, 0, 0);
      checks++; if (timed_out != 0 || n_res != 64) begin failures++; $display("FAIL sat_step%0d_results: got %0d expected 64", s, n_res); end
      checks++; if (res_spk[10] !== ex[s]) begin failures++; $display("FAIL sat_step%0d_n10: got %b expected %b", s, res_spk[10], ex[s]); end
      checks++; if (n_spk != int'(ex[s])) begin failures++; $display("FAIL sat_step%0d_total: got %0d expected %0d", s, n_spk, ex[s]); end
    end
  endtask

  task automatic test_stalls();
    logic ex;
    for (int i = 0; i < N; i++) cur_vec[i] = (i % 3 == 0) ? 16'sd40 : 16'sd0;
    run_step(1'b0, 40, 1, 0, 0);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL stall_timeout: got %0d expected 0", timed_out); end
    checks++; if (n_res != 64) begin failures++; $display("FAIL stall_results: got %0d expected 64", n_res); end
    checks++; if (order_err != 0) begin failures++; $display("FAIL stall_order: got %0d expected 0", order_err); end
    checks++; if (done_bad != 0) begin failures++; $display("FAIL stall_done_at_63: got %0d expected 0", done_bad); end
    checks++; if (n_spk != 22) begin failures++; $display("FAIL stall_spikes: got %0d expected 22", n_spk); end
    for (int i = 0; i < N; i++) begin
      ex = (i % 3 == 0);
      checks++; if (res_spk[i] !== ex) begin failures++; $display("FAIL stall_spk[%0d]: got %b expected %b", i, res_spk[i], ex); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) cur_vec[i] = '0;
    run_step(1'b0, 0, 0, 1, 0);
    checks++; if (timed_out != 0 || n_res != 64) begin failures++; $display("FAIL b2b_first_results: got %0d expected 64", n_res); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (cur_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", cur_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    run_step(1'b0, 0, 0, 0, 1);
    checks++; if (timed_out != 0 || n_res != 64) begin failures++; $display("FAIL b2b_second_results: got %0d expected 64", n_res); end
    checks++; if (order_err != 0) begin failures++; $display("FAIL b2b_order: got %0d expected 0", order_err); end
    checks++; if (step_cycles != 65) begin failures++; $display("FAIL b2b_cycles: got %0d expected 65", step_cycles); end
    checks++; if (n_spk != 0) begin failures++; $display("FAIL b2b_spikes: got %0d expected 0", n_spk); end
  endtask

  // Abort a step with rst_n after 30 beats; neurons 0..29 must keep their update.
  task automatic test_reset_midstep();
    int   cnt = 0;
    int   k = 0;
    int   cyc = 0;
    int   aborted_done = 0;
    logic lv = 1'b0;
    logic lr = 1'b0;
    logic ex;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    while (busy && cnt < 200) begin cnt++; @(negedge clk); end
    start = 1'b1; leak_en = 1'b0;
    @(negedge clk);
    while (k < 30 && cyc < 500) begin
      start = 1'b0;
      if (done) aborted_done++;
      if (lv && lr) k++;
      if (k < 30) begin
        cur_valid = 1'b1; cur_data = 16'sd10;
        lv = 1'b1; lr = cur_ready;
        cyc++;
        @(negedge clk);
      end
    end
    rst_n = 1'b0; cur_valid = 1'b0;
    #1;
    checks++; if (k != 30) begin failures++; $display("FAIL rstmid_beats: got %0d expected 30", k); end
    checks++; if (spk_valid !== 1'b0) begin failures++; $display("FAIL rstmid_spk_valid: got %b expected 0", spk_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    repeat (2) begin
      @(negedge clk);
      if (done) aborted_done++;
    end
    checks++; if (aborted_done != 0) begin failures++; $display("FAIL rstmid_done: got %0d expected 0", aborted_done); end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) cur_vec[i] = 16'sd25;
    run_step(1'b0, 0, 0, 0, 0);
    checks++; if (timed_out != 0 || n_res != 64) begin failures++; $display("FAIL rstmid_results: got %0d expected 64", n_res); end
    checks++; if (order_err != 0) begin failures++; $display("FAIL rstmid_order: got %0d expected 0", order_err); end
    for (int i = 0; i < N; i++) begin
      ex = (i < 30);
      checks++; if (res_spk[i] !== ex) begin failures++; $display("FAIL rstmid_spk[%0d]: got %b expected %b", i, res_spk[i], ex); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_zero_step();
    test_refractory();
    test_leak();
    test_saturation();
    test_stalls();
    test_back_to_back();
    test_reset_midstep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
